// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
//   Constants and types shared by the instruction-memory loader and the
//   processor top level.
//   - IMEM_ADDR_W    : instruction memory word-address width (1K words)
//   - IMEM_DATA_W    : instruction word width
//   - BYTES_PER_WORD : stream bytes per instruction word
//   - state_t        : loader FSM states
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    localparam int IMEM_ADDR_W    = 10;
    localparam int IMEM_DATA_W    = 32;
    localparam int BYTES_PER_WORD = IMEM_DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        BYTES,
        WRITE,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// -----------------------------------------------------------------------------
// byte_assembler
//   Packs a byte stream into big-endian words: each accepted byte enters at
//   the LSB end and pushes earlier bytes up, so the first byte of a word ends
//   up in the most significant byte.
//   Ports:
//     clk       : system clock
//     rst       : synchronous active-low reset
//     clear     : drop the partial word and restart the byte count
//     shift_en  : accept byte_in this cycle
//     byte_in   : stream byte
//     word      : assembly register (complete from the cycle after word_full)
//     word_full : this shift completes a word
// -----------------------------------------------------------------------------
module byte_assembler
    import imem_loader_pkg::*;
#(
    parameter int DATA_W = IMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] word,
    output logic              word_full
);

    localparam int NBYTES = DATA_W / 8;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the values that existed before the clock edge.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            word <= '0;
            cnt  <= '0;
        end else if (shift_en) begin
            word <= (word << 8) | DATA_W'(byte_in);
            cnt  <= (cnt == CNT_W'(NBYTES - 1)) ? '0 : cnt + 1'b1;
        end
    end

    // Combinational so the FSM can step into WRITE on the same edge that
    // shifts in the final byte; the register then holds the full word.
    assign word_full = shift_en && (cnt == CNT_W'(NBYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Loads a program image into instruction memory from a byte stream.
//   Stream format: 16-bit big-endian word count, then that many big-endian
//   words. Words are written to consecutive addresses starting at 0. The core
//   is held stopped while loading and released after the last word.
//   Ports:
//     clk, rst          : clock, synchronous active-low reset
//     start             : begin a load (honoured in IDLE, DONE, ERR)
//     in_valid/in_data  : byte stream; in_ready accepts it
//     mem_we/addr/wdata : instruction memory write port (one-cycle strobe)
//     busy              : load in progress
//     done / err        : sticky result of the last load
//     cpu_run           : core may run
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = IMEM_ADDR_W,
    parameter int DATA_W    = IMEM_DATA_W,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_run
);

    state_t          state;
    logic [15:0]     length;
    logic [ADDR_W:0] word_cnt;   // one extra bit so MAX_WORDS fits

    logic            xfer;
    logic            start_ok;
    logic [15:0]     len_full;
    logic            last_word;
    logic            asm_full;

    assign xfer      = in_valid && in_ready;
    assign start_ok  = start && (state == IDLE || state == DONE || state == ERR);
    // Complete length as it will be once the low byte now on the bus lands.
    assign len_full  = {length[15:8], in_data};
    assign last_word = (16'(word_cnt) + 16'd1) == length;

    byte_assembler #(
        .DATA_W (DATA_W)
    ) u_asm (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_ok),
        .shift_en  (xfer && (state == BYTES)),
        .byte_in   (in_data),
        .word      (mem_wdata),
        .word_full (asm_full)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            cpu_run  <= 1'b0;
            length   <= '0;
            word_cnt <= '0;
        end else begin
            mem_we <= 1'b0;  // single-cycle strobe, raised only on entry to WRITE

            case (state)
                IDLE, DONE, ERR: begin
                    if (start_ok) begin
                        state    <= LEN_HI;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        cpu_run  <= 1'b0;
                        mem_addr <= '0;
                        word_cnt <= '0;
                        length   <= '0;
                    end
                end

                LEN_HI: begin
                    if (xfer) begin
                        length[15:8] <= in_data;
                        state        <= LEN_LO;
                    end
                end

                LEN_LO: begin
                    if (xfer) begin
                        length[7:0] <= in_data;
                        if (len_full == 16'd0) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            cpu_run  <= 1'b1;
                        end else if (len_full > 16'(MAX_WORDS)) begin
                            state    <= ERR;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            err      <= 1'b1;
                        end else begin
                            state <= BYTES;
                        end
                    end
                end

                BYTES: begin
                    if (asm_full) begin
                        state    <= WRITE;
                        in_ready <= 1'b0;
                        mem_we   <= 1'b1;
                    end
                end

                WRITE: begin
                    if (last_word) begin
                        // Address is left on the final word, never wrapped.
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        cpu_run <= 1'b1;
                    end else begin
                        state    <= BYTES;
                        in_ready <= 1'b1;
                        word_cnt <= word_cnt + 1'b1;
                        mem_addr <= mem_addr + 1'b1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Directed stimulus with a write scoreboard: the stimulus pushes each
//   expected (address, word) before streaming an image; a monitor pops and
//   compares on every mem_we pulse.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_run;

    imem_loader #(
        .ADDR_W    (10),
        .DATA_W    (32),
        .MAX_WORDS (1024)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cpu_run   (cpu_run)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] stim_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int          we_count     = 0;
    int          last_we_cyc  = 0;
    logic [9:0]  last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;
    int          last_xfer_cyc  = 0;
    int          first_xfer_cyc = 0;
    bit          chk_ready = 1'b0;
    wr_t         mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic finish_tb();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (mem_we) begin
            we_count++;
            last_we_cyc  = cyc;
            last_wr_addr = mem_addr;
            last_wr_data = mem_wdata;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
                check("wr_data", mem_wdata, mon_e.data);
            end
        end
        if (chk_ready) check("in_ready_only_low_in_write", 32'(in_ready), 32'(!mem_we));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic push_exp(input logic [9:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic push_word(input logic [31:0] d);
        for (int k = 3; k >= 0; k--) stim_q.push_back(d[8*k +: 8]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0 for byte 0x%0h, expected 1", b);
            finish_tb();
        end
        step();
        last_xfer_cyc = cyc;
        in_valid      = 1'b0;
    endtask

    // Streams stim_q with `gap` idle cycles between bytes; start is pulsed
    // during the gap after byte index start_at (use -1 for never).
    task automatic send_stim(input int gap, input int start_at);
        int nb;
        nb = stim_q.size();
        for (int i = 0; i < nb; i++) begin
            send_byte(stim_q[i]);
            if (i == 0) first_xfer_cyc = last_xfer_cyc;
            if (i != nb - 1 && gap > 0) begin
                if (i == start_at) start = 1'b1;
                repeat (gap) begin
                    step();
                    start = 1'b0;
                end
            end
        end
        stim_q.delete();
    endtask

    // Returns at a falling edge once done or err is high.
    task automatic wait_end(output int c);
        int n;
        n = 0;
        @(negedge clk);
        while (!(done || err) && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!(done || err)) begin
            n_tests++;
            n_fail++;
            $display("FAIL end_timeout: done=%0b err=%0b, expected one of them high", done, err);
            finish_tb();
        end
        c = cyc;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_mem_we"},   32'(mem_we),   32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_wdata"},    mem_wdata,     32'd0);
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_done"},     32'(done),     32'd0);
        check({tag, "_err"},      32'(err),      32'd0);
        check({tag, "_cpu_run"},  32'(cpu_run),  32'd0);
    endtask

    initial begin
        #2_000_000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        finish_tb();
    end

    initial begin
        int c;
        int we0;

        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        step();
        rst = 1'b1;
        step();

        // Basic back-to-back load of two words.
        push_exp(10'd0, 32'h12345678);
        push_exp(10'd1, 32'h9ABCDEF0);
        stim_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        we0 = we_count;
        pulse_start();
        send_stim(0, -1);
        wait_end(c);
        // First byte occupies cycle 1; done is high from cycle 13.
        check("basic_first_byte_to_done", 32'(c - first_xfer_cyc), 32'd11);
        check("basic_done_after_last_write", 32'(c - last_we_cyc), 32'd1);
        check("basic_writes", 32'(we_count - we0), 32'd2);
        check("basic_done", 32'(done), 32'd1);
        check("basic_cpu_run", 32'(cpu_run), 32'd1);
        check("basic_busy", 32'(busy), 32'd0);
        step();

        // Same image with 3-cycle stalls; start pulsed mid-load is ignored.
        push_exp(10'd0, 32'h12345678);
        push_exp(10'd1, 32'h9ABCDEF0);
        stim_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        we0 = we_count;
        pulse_start();
        @(negedge clk);
        check("restart_clears_done", 32'(done), 32'd0);
        check("restart_drops_cpu_run", 32'(cpu_run), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        step();
        chk_ready = 1'b1;
        send_stim(3, 4);
        chk_ready = 1'b0;
        wait_end(c);
        check("stall_writes", 32'(we_count - we0), 32'd2);
        check("stall_done", 32'(done), 32'd1);
        check("stall_cpu_run", 32'(cpu_run), 32'd1);
        step();

        // Zero length.
        stim_q = '{8'h00, 8'h00};
        we0 = we_count;
        pulse_start();
        send_stim(0, -1);
        wait_end(c);
        check("zero_done_next_cycle", 32'(c - last_xfer_cyc), 32'd0);
        check("zero_no_write", 32'(we_count - we0), 32'd0);
        check("zero_cpu_run", 32'(cpu_run), 32'd1);
        check("zero_err", 32'(err), 32'd0);
        step();

        // Over length (1025), then recover with a one-word image.
        stim_q = '{8'h04, 8'h01};
        we0 = we_count;
        pulse_start();
        send_stim(0, -1);
        wait_end(c);
        check("over_err", 32'(err), 32'd1);
        check("over_done", 32'(done), 32'd0);
        check("over_cpu_run", 32'(cpu_run), 32'd0);
        check("over_busy", 32'(busy), 32'd0);
        step();
        in_valid = 1'b1;
        in_data  = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("over_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        check("over_no_write", 32'(we_count - we0), 32'd0);
        // in_valid stays high with 0xAA through the start cycle; that byte
        // must not be taken as the length header.
        push_exp(10'd0, 32'hCAFEBABE);
        stim_q = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
        pulse_start();
        send_stim(0, -1);
        wait_end(c);
        check("recover_err_cleared", 32'(err), 32'd0);
        check("recover_done", 32'(done), 32'd1);
        check("recover_writes", 32'(we_count - we0), 32'd1);
        step();

        // Full-size image: 1024 words, word i = i.
        stim_q.push_back(8'h04);
        stim_q.push_back(8'h00);
        for (int i = 0; i < 1024; i++) begin
            push_word(32'(i));
            push_exp(10'(i), 32'(i));
        end
        we0 = we_count;
        pulse_start();
        send_stim(0, -1);
        wait_end(c);
        check("full_writes", 32'(we_count - we0), 32'd1024);
        check("full_last_addr", 32'(last_wr_addr), 32'd1023);
        check("full_last_data", last_wr_data, 32'd1023);
        check("full_addr_no_wrap", 32'(mem_addr), 32'd1023);
        check("full_done", 32'(done), 32'd1);
        we0 = we_count;
        repeat (5) step();
        check("full_no_extra_writes", 32'(we_count - we0), 32'd0);

        // Reset after 3 of 5 words.
        stim_q = '{8'h00, 8'h05};
        for (int i = 0; i < 3; i++) begin
            push_word(32'hA0000000 + 32'(i));
            push_exp(10'(i), 32'hA0000000 + 32'(i));
        end
        stim_q.push_back(8'h55);
        stim_q.push_back(8'h66);
        we0 = we_count;
        pulse_start();
        send_stim(0, -1);
        check("midload_writes_before_reset", 32'(we_count - we0), 32'd3);
        rst = 1'b0;
        step();
        @(negedge clk);
        check_reset_outputs("midload_reset");
        check("midload_pending", 32'(exp_q.size()), 32'd0);
        step();
        rst = 1'b1;
        step();
        push_exp(10'd0, 32'h11223344);
        stim_q = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        we0 = we_count;
        pulse_start();
        send_stim(0, -1);
        wait_end(c);
        check("reload_writes", 32'(we_count - we0), 32'd1);
        check("reload_addr", 32'(last_wr_addr), 32'd0);
        check("reload_done", 32'(done), 32'd1);
        check("final_pending", 32'(exp_q.size()), 32'd0);
        step();

        finish_tb();
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart of the processor's instruction fetch path.
- Accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them sequentially into instruction memory through its write port, starting at address 0.
- Holds the core stopped (cpu_run=0) while loading, and releases it once the full program image is written.

Parameters:
- ADDR_W, 10, instruction memory word-address width (1K words).
- DATA_W, 32, instruction word width; must be a multiple of 8.
- MAX_WORDS, 1024, largest legal image length in words; must be ≤ 2^ADDR_W.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte this cycle. A transfer occurs when in_valid & in_ready.
- mem_we  out  1  one-cycle instruction memory write enable.
- mem_addr  out  ADDR_W  write word address.
- mem_wdata  out  DATA_W  write word.
- busy  out  1  load in progress.
- done  out  1  last load completed successfully (sticky).
- err  out  1  last load rejected for bad length (sticky).
- cpu_run  out  1  1 = core may run; 0 = core held in reset by top level.

Behaviour:
- Reset (rst=0 at an edge):
  - State = IDLE.
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, cpu_run=0.
  - Word counter, byte counter and length register cleared.
  - Reset mid-load abandons the load; words already written stay in memory.
- States:
  - IDLE: in_ready=0. On start: go to LEN_HI, busy=1, done=0, err=0, cpu_run=0, mem_addr=0.
  - LEN_HI: in_ready=1. On a transfer, length[15:8] = byte; go to LEN_LO.
  - LEN_LO: in_ready=1. On a transfer, length[7:0] = byte. Evaluate the full length in the same cycle:
    - length == 0: go to DONE.
    - length > MAX_WORDS: go to ERR.
    - otherwise: go to BYTES.
  - BYTES: in_ready=1. Shift each transferred byte into the assembly register MSB-first; the first byte lands in bits [31:24]. When the 4th byte transfers, go to WRITE.
  - WRITE: exactly one cycle.
    - mem_we=1; mem_wdata = assembled word; mem_addr = current word index.
    - in_ready=0 in this cycle, so no byte is accepted.
    - Next cycle: if the written word was the last one (index == length-1), go to DONE. Otherwise increment mem_addr and return to BYTES.
  - DONE: busy=0, done=1, cpu_run=1, in_ready=0. Stay until start.
  - ERR: busy=0, err=1, cpu_run=0, in_ready=0. Stay until start. Bytes that follow the header are not consumed.
- Handshake and timing:
  - in_valid=0 stalls any receiving state indefinitely with no timeout.
  - Byte order and count do not depend on gap timing.
- Latency:
  - Each word is written 1 cycle after its 4th byte.
  - Back-to-back stream: 5 cycles per word.
  - done rises 1 cycle after the final WRITE.
- Boundaries:
  - length == MAX_WORDS: final write goes to address MAX_WORDS-1, and mem_addr does not wrap before DONE.
  - start asserted while busy: ignored.
  - start in DONE or ERR: clears the sticky flags and drops cpu_run the next cycle.
  - start and in_valid in the same cycle as IDLE→LEN_HI: that byte is not consumed, because in_ready=0 in IDLE.
- Width rules:
  - Word counter is ADDR_W+1 bits so that a count of MAX_WORDS is representable.
  - The length comparison is unsigned 16-bit.

Decomposition:
- Shared package:
  - state enum (IDLE, LEN_HI, LEN_LO, BYTES, WRITE, DONE, ERR);
  - BYTES_PER_WORD = DATA_W/8;
  - IMEM_ADDR_W = 10 constant, shared with the processor top.
- One natural sub-module: byte_assembler. It holds the shift register and the 2-bit byte counter, with inputs shift_en and clear and outputs word and word_full. The FSM, counters and handshake stay in imem_loader.

Test Plan:
- Basic load: start, then stream 00 02 | 12 34 56 78 | 9A BC DE F0 back-to-back.
  - Writes: (addr 0, 0x12345678), then (addr 1, 0x9ABCDEF0).
  - done=1 and cpu_run=1 one cycle after the second write.
  - Total 12 cycles from the first byte to done.
- Stalls: same image with in_valid=0 for 3 cycles between each byte. Identical writes and data; in_ready=0 only in the WRITE cycles.
- Zero length: header 00 00.
  - DONE on the cycle after the LEN_LO transfer; no mem_we pulse; cpu_run=1.
- Over length: header 04 01 (1025).
  - ERR; err=1, cpu_run=0; no mem_we.
  - The next byte is not accepted (in_ready=0).
  - A new start with a valid image then loads correctly and clears err.
- Full-size image: length 1024 with word i = i. The last write is at addr 1023 with data 1023, and there are no writes beyond it.
- Reset mid-load: rst=0 after 3 of 5 words are written.
  - All outputs return to their reset values next cycle.
  - A subsequent start reloads from address 0.
